// File: rtl/nn_pkg.sv
// Shared constants and types for the neural network output stage and the argmax back-end.
package nn_pkg;

  localparam int NN_OUT_WIDTH = 48;
  localparam int NN_CLASSES   = 10;
  localparam int NN_IDX_WIDTH = $clog2(NN_CLASSES);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

  typedef struct packed {
    logic signed [NN_OUT_WIDTH-1:0] best;
    logic signed [NN_OUT_WIDTH-1:0] second;
    logic [NN_IDX_WIDTH-1:0]        best_idx;
  } top2_t;

endpackage

// File: rtl/nn_argmax_classifier_if.sv
// Score-vector input handshake and classification result handshake.
interface nn_argmax_classifier_if
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_OUT_WIDTH,
  parameter int NEURON_NUM = NN_CLASSES,
  parameter int IDX_WIDTH  = $clog2(NEURON_NUM)
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] scores [NEURON_NUM];
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_WIDTH-1:0]         class_idx;
  logic signed [DATA_WIDTH-1:0] max_score;
  logic [DATA_WIDTH:0]          margin;

  modport master (
    output in_valid, scores, out_ready,
    input  in_ready, out_valid, class_idx, max_score, margin
  );

  modport slave (
    input  in_valid, scores, out_ready,
    output in_ready, out_valid, class_idx, max_score, margin
  );

endinterface

// File: rtl/nn_top2_update.sv
// Running top-2 update: a candidate must be strictly greater to displace, so ties keep the lower index.
module nn_top2_update
  import nn_pkg::*;
(
  input  top2_t                          cur,
  input  logic signed [NN_OUT_WIDTH-1:0] cand,
  input  logic [NN_IDX_WIDTH-1:0]        cand_idx,
  output top2_t                          nxt
);

  always_comb begin
    nxt = cur;
    if ($signed(cand) > $signed(cur.best)) begin
      nxt.second   = cur.best;
      nxt.best     = cand;
      nxt.best_idx = cand_idx;
    end else if ($signed(cand) > $signed(cur.second)) begin
      nxt.second = cand;
    end
  end

endmodule

// File: rtl/nn_argmax_classifier.sv
// Captures a score vector, scans it one score per cycle for the top two, and holds
// class index, max score and margin until the consumer accepts them.
//
// state | meaning
// IDLE  | in_ready high, waiting for a score vector
// SCAN  | folding bank[k] into the running top-2, k = 2 .. NEURON_NUM-1
// DONE  | result held with out_valid high until out_ready
module nn_argmax_classifier
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_OUT_WIDTH,
  parameter int NEURON_NUM = NN_CLASSES,
  parameter int IDX_WIDTH  = $clog2(NEURON_NUM)
) (
  input logic                   clk,
  input logic                   rst,
  nn_argmax_classifier_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NEURON_NUM - 1);
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  argmax_state_t                state;
  logic signed [DATA_WIDTH-1:0] bank [NEURON_NUM];
  logic [IDX_WIDTH-1:0]         k;
  top2_t                        top2_q;
  top2_t                        top2_cur;
  top2_t                        top2_nxt;
  logic signed [DATA_WIDTH-1:0] cand;
  logic [IDX_WIDTH-1:0]         cand_idx;
  logic [DATA_WIDTH:0]          margin_nxt;

  logic                         in_ready_q;
  logic                         out_valid_q;
  logic [IDX_WIDTH-1:0]         class_idx_q;
  logic signed [DATA_WIDTH-1:0] max_score_q;
  logic [DATA_WIDTH:0]          margin_q;

  // Preload is expressed as (score0, idx 0) vs. candidate score1 with second at the
  // most negative value, so the one update rule also produces the initial ordering.
  always_comb begin
    top2_cur = top2_q;
    cand     = bank[k];
    cand_idx = k;
    if (state == IDLE) begin
      top2_cur.best     = bus.scores[0];
      top2_cur.second   = MIN_SCORE;
      top2_cur.best_idx = '0;
      cand              = bus.scores[1];
      cand_idx          = IDX_WIDTH'(1);
    end
  end

  nn_top2_update u_top2_update (
    .cur      (top2_cur),
    .cand     (cand),
    .cand_idx (cand_idx),
    .nxt      (top2_nxt)
  );

  // One extra bit keeps max - min representable without wrap.
  assign margin_nxt = {top2_nxt.best[DATA_WIDTH-1], top2_nxt.best}
                    - {top2_nxt.second[DATA_WIDTH-1], top2_nxt.second};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      top2_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      class_idx_q <= '0;
      max_score_q <= '0;
      margin_q    <= '0;
      for (int i = 0; i < NEURON_NUM; i++) bank[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < NEURON_NUM; i++) bank[i] <= bus.scores[i];
            top2_q     <= top2_nxt;
            in_ready_q <= 1'b0;
            if (NEURON_NUM == 2) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              class_idx_q <= top2_nxt.best_idx;
              max_score_q <= top2_nxt.best;
              margin_q    <= margin_nxt;
            end else begin
              k     <= IDX_WIDTH'(2);
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          top2_q <= top2_nxt;
          if (k == LAST_IDX) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            class_idx_q <= top2_nxt.best_idx;
            max_score_q <= top2_nxt.best;
            margin_q    <= margin_nxt;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.class_idx = class_idx_q;
  assign bus.max_score = max_score_q;
  assign bus.margin    = margin_q;

endmodule

// File: doc/nn_argmax_classifier.md
# nn_argmax_classifier

Classification back-end directly downstream of `neural_network`. It captures the 10 signed layer-2 scores (`output_data`) on a valid strobe and scans them serially, one score per cycle. It then reports the winning class index, its score, and the margin over the runner-up, holding the result until the consumer accepts it. It turns raw network scores into a digit decision for the display/UART side of the design.

## Interface
- `DATA_WIDTH`, 48: score width; matches `LAYER2_DATA_WIDTH+8` of the network output.
- `NEURON_NUM`, 10: number of scores/classes; must be ≥ 2.
- `IDX_WIDTH`, `$clog2(NEURON_NUM)`: width of the class index.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset; one clock, synchronous, active-high reset.
- `in_valid`  in  1  the score vector is valid this cycle.
- `in_ready`  out  1  the block can accept a vector (high only in IDLE).
- `scores`  in  `[DATA_WIDTH-1:0]` signed x NEURON_NUM (unpacked)  network outputs.
- `out_valid`  out  1  the result is valid and held.
- `out_ready`  in  1  the consumer accepts the result.
- `class_idx`  out  IDX_WIDTH  index of the maximum score.
- `max_score`  out  DATA_WIDTH signed  value of the maximum score.
- `margin`  out  DATA_WIDTH+1 unsigned  max minus second-highest score.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset puts the FSM in IDLE.
- Reset values: all outputs 0 except `in_ready`=1; the capture bank and scan counter are cleared.
- **IDLE:** `in_ready`=1. On `in_valid`:
  - copy all `scores` into an internal bank;
  - load best = (score[0], idx 0) and second = (score[1]);
  - if score[1] > score[0], swap them, so best = (score[1], idx 1);
  - set k=2 and go to SCAN.
- **SCAN:** each cycle compares bank[k] against the running top-2. All compares are signed.
  - If bank[k] > best: second ← best, best ← (bank[k], k).
  - Else if bank[k] > second: second ← bank[k].
  - Ties never replace, so the lowest index wins and an equal value does not displace second.
  - At k = NEURON_NUM-1 the update is applied and the FSM goes to DONE.
  - If NEURON_NUM = 2, IDLE goes straight to DONE.
- **DONE:** `out_valid`=1 with `class_idx`, `max_score` and `margin` stable.
  - `margin` = best − second, computed sign-extended to DATA_WIDTH+1; it is never negative.
  - When `out_ready`=1, go to IDLE and drop `out_valid`.
  - Outputs keep their last values in IDLE, but they are only meaningful while `out_valid` is high.
- `in_valid` outside IDLE is ignored; there is no queueing, and upstream must retry or hold.
- `scores` are sampled only on the accept edge. Later changes on `scores` do not affect the scan in progress.
- `rst` in any state, mid-scan included, aborts the scan and returns to IDLE with the reset values above on the next edge.

## Timing
- The accept edge is E0 (`in_valid` and `in_ready` both high).
- The SCAN update for index k happens at edge E(k-1).
- `out_valid` rises after edge E(NEURON_NUM-2): 8 cycles after acceptance for the default configuration.
- The acceptance edge for the result is the edge where `out_valid`=1 and `out_ready`=1.
  - `in_ready` returns high in the cycle after that edge.
  - A new vector can be accepted on the following edge.
  - Back-to-back throughput is therefore NEURON_NUM cycles per vector with `out_ready` tied high.
- `out_ready` high before `out_valid` is harmless; it has no effect outside DONE.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `nn_pkg`:
  - `NN_OUT_WIDTH`=48 and `NN_CLASSES`=10 constants, reused by `neural_network`;
  - `argmax_state_t` enum {IDLE, SCAN, DONE};
  - a `top2_t` struct {best, second, best_idx}.
- Sub-module `nn_top2_update`: combinational. It takes the current `top2_t`, a candidate value and a candidate index, and returns the next `top2_t` using the tie rules above. It is instantiated once in the scan datapath, and the IDLE preload reuses the same rule.
- Top level holds the FSM, the capture bank, the counter k and the output registers.

## Test plan
- **Basic scan:** scores = {0,5,−3,100,7,2,9,−50,1,99}, `out_ready`=1.
  - Expect `class_idx`=3, `max_score`=100, `margin`=1.
  - `out_valid` rises 8 cycles after accept.
- **Ties and negatives:** all scores = −7.
  - Expect `class_idx`=0, `max_score`=−7, `margin`=0.
- **Extremes and width:** score[9]=2^47−1, all others = −2^47.
  - Expect `class_idx`=9 and `margin`=2^48−1, with no overflow.
- **Backpressure:** hold `out_ready`=0 for 20 cycles in DONE.
  - Outputs stay stable and `in_ready`=0 throughout.
  - Pulses on `in_valid` and changes on `scores` during that time are ignored.
  - Releasing `out_ready` gives one handshake, then `in_ready`=1.
- **Reset mid-scan:** assert `rst` at k=5 of the vector {9,1,1,1,1,1,1,1,1,0}.
  - Next edge: IDLE, `out_valid`=0, `in_ready`=1.
  - A fresh vector then produces the correct result for that vector only.
- **Back-to-back:** two vectors with maxima at index 6 and index 2, `out_ready` tied high.
  - Two results in order; the second accept is exactly NEURON_NUM cycles after the first.
